linebuffer_window41: RTL and testbench
======================================

// Module: linebuffer_window41
// PURPOSE
//  Line-buffer stage upstream of the 41-term inner-product block. Takes a raster-order pixel stream and
//  keeps WIN_H-1 previous image rows in line buffers. Emits one 41-entry feature vector per valid window.
//  xarray[0] = bias constant 1; xarray[1..40] = a 5x8 pixel window. Output feeds the inner-product xarray input.
// PARAMETERS
//  IMG_W  640  pixels per image row (>= WIN_W)
//  IMG_H  480  rows per frame (>= WIN_H)
//  PIX_W  8    input pixel width; zero-extended to 32 bits on output
//  WIN_W  8    window columns (fixed: WIN_W*WIN_H must equal 40)
//  WIN_H  5    window rows
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      pixel present on in_pix
//  in_ready   out  1      stage can accept a pixel this cycle
//  in_pix     in   PIX_W  pixel, raster order (row-major, left to right)
//  out_valid  out  1      xarray holds a complete window
//  out_ready  in   1      consumer takes the window this cycle
//  xarray     out  32x41  feature vector [0:40]
// BEHAVIOUR
//  - Pixel accept: in_valid && in_ready. Window accept: out_valid && out_ready.
//  - in_ready = !out_valid || out_ready. The stage is a single-entry skid; nothing is accepted while a window is stalled.
//  - Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted pixel.
//    col wraps to 0 and row increments at col==IMG_W-1.
//    row wraps to 0 at the last pixel of the frame (IMG_H-1, IMG_W-1); the next pixel starts a new frame.
//  - Line buffers are WIN_H-1 RAMs of IMG_W x PIX_W, indexed by col, cascaded.
//    On accept: the buffers shift vertically, and the window shift register moves one column left, taking in the new column.
//  - Mapping: xarray[1 + r*WIN_W + c] = pixel(row-(WIN_H-1)+r, col-(WIN_W-1)+c). r=0 is the top row; c=0 is the leftmost column.
//  - xarray[0] = 32'd1 at all times, including during reset.
//  - Window rule: out_valid is set 1 cycle after accepting a pixel with row >= WIN_H-1 and col >= WIN_W-1.
//    It stays set until the window is accepted. If the window is accepted with no new qualifying pixel, out_valid clears.
//    Latency is 1 clock from pixel accept to out_valid.
//  - No windows straddle a row wrap. Columns 0..WIN_W-2 of each row only fill the shift register.
//  - xarray is stable while out_valid && !out_ready.
//  - Reset (async, any time, including mid-frame): out_valid=0, in_ready=1, col=row=0, window regs=0, xarray[1..40]=0.
//    Line buffer RAM contents are not cleared. Validity is derived from the counters only, so stale RAM data never reaches a valid window.
//  - Simultaneous window accept and pixel accept: the new window replaces the old one in the same edge, and out_valid stays 1.
//  - in_pix is ignored when in_valid=0. Gaps in in_valid are allowed at any point.
// CONFIGURATION
//  - Macro LINEBUF_SOF_EN. Defined: adds input port in_sof (1 bit), sampled only on pixel accept.
//    When in_sof=1 the pixel is treated as (row 0, col 0): counters are forced before the update, and any pending out_valid is left to drain normally.
//  - Undefined: no in_sof port. Frame alignment comes only from reset and the counter wrap.
// STRUCTURE
//  - Shared package linebuffer_pkg holds the constants and typedefs:
//    N_FEAT=41, WIN_W, WIN_H, FEAT_W=32, typedef logic [FEAT_W-1:0] feat_t, and localparam BIAS=32'd1.
//    The inner-product stage uses the same package.
//  - One sub-module, linebuffer_row_ram: single-port read-before-write, IMG_W x PIX_W, 1 write + 1 read per accept, same address.
//    It is instantiated WIN_H-1 times.
//  - Top level contains the counters, the window shift register (WIN_H x WIN_W x PIX_W), the handshake, and the output assembly.
// TESTING (IMG_W=16, IMG_H=8, PIX_W=8; pixel value = (row*16+col) mod 256)
//  1. Stream one frame, out_ready=1. First out_valid comes 1 clk after pixel (4,7):
//     xarray[0]=1, xarray[1]=0, xarray[8]=7, xarray[33]=64, xarray[40]=71.
//     The frame yields 4 rows x 9 windows = 36 windows.
//  2. Same stream with out_ready=0 for 5 cycles at the first window: in_ready=0, xarray held at the window ending at 71.
//     Release -> the next window ends at pixel 72, and no pixel is lost or duplicated.
//  3. Two back-to-back frames: the first window of frame 2 ends at (4,7), with xarray[1]=0 and no data from frame 1.
//     The total is 72 windows.
//  4. Assert rst mid-frame at pixel (5,3): out_valid=0 immediately.
//     Restart the stream from (0,0): the first window comes again after (4,7), with identical values to scenario 1.
//  5. in_valid toggling 1/0 every cycle: the same 36 windows in the same order as scenario 1, with 1-clk latency after each qualifying accept.
//  6. LINEBUF_SOF_EN: assert in_sof at pixel (6,2) and restart the raster from 0 -> the next window ends at (4,7) of the new frame.

Source files
------------

// File: rtl/linebuffer_window41_pkg.sv
// ---------------------------------------------------------------------------
// linebuffer_pkg
//   Constants and types shared by the line-buffer stage and the 41-term
//   inner-product stage that consumes its feature vector.
//   N_FEAT  : feature-vector length (bias + WIN_W*WIN_H pixels)
//   WIN_W/H : window geometry (WIN_W*WIN_H must equal N_FEAT-1)
//   FEAT_W  : width of one feature entry
//   feat_t  : one feature entry
//   BIAS    : constant placed in feature slot 0
// ---------------------------------------------------------------------------
package linebuffer_pkg;

  localparam int N_FEAT = 41;
  localparam int WIN_W  = 8;
  localparam int WIN_H  = 5;
  localparam int FEAT_W = 32;

  typedef logic [FEAT_W-1:0] feat_t;

  localparam feat_t BIAS = 32'd1;

  // Slot of window pixel (r, c) inside the feature vector; slot 0 is the bias.
  function automatic int feat_index(input int r, input int c);
    return 1 + r * WIN_W + c;
  endfunction

endpackage

// File: rtl/linebuffer_window41_if.sv
// ---------------------------------------------------------------------------
// linebuffer_window41_if
//   Pixel-stream input and feature-vector output of the line-buffer stage.
//   Parameter PIX_W must match the PIX_W of the connected linebuffer_window41.
//   Signals:
//     in_valid  pixel present on in_pix
//     in_ready  stage can accept a pixel this cycle
//     in_pix    pixel, raster order
//     in_sof    start-of-frame marker (only when LINEBUF_SOF_EN is defined)
//     out_valid xarray holds a complete window
//     out_ready consumer takes the window this cycle
//     xarray    feature vector [0:N_FEAT-1]
//   Modports:
//     master  pixel producer / window consumer side
//     slave   the line-buffer stage itself
// ---------------------------------------------------------------------------
interface linebuffer_window41_if
  import linebuffer_pkg::*;
#(
  parameter int PIX_W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
`ifdef LINEBUF_SOF_EN
  logic             in_sof;
`endif
  logic             out_valid;
  logic             out_ready;
  feat_t            xarray [0:N_FEAT-1];

  modport master (
`ifdef LINEBUF_SOF_EN
    output in_sof,
`endif
    output in_valid,
    output in_pix,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  xarray
  );

  modport slave (
`ifdef LINEBUF_SOF_EN
    input  in_sof,
`endif
    input  in_valid,
    input  in_pix,
    input  out_ready,
    output in_ready,
    output out_valid,
    output xarray
  );

endinterface

// File: rtl/linebuffer_window41_row_ram.sv
// ---------------------------------------------------------------------------
// linebuffer_row_ram
//   One image-row line buffer: DEPTH x WIDTH, single port, read-before-write.
//   The read is combinational at addr, so in the cycle a pixel is accepted the
//   old entry (previous row, same column) is visible on rdata while the new
//   value is written at the clock edge.
//   Ports:
//     clk    rising-edge clock
//     we     write enable (one write per accepted pixel)
//     addr   column index
//     wdata  value stored at addr
//     rdata  value stored at addr before this cycle's write
//   Contents are deliberately not reset.
// ---------------------------------------------------------------------------
module linebuffer_row_ram #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/linebuffer_window41.sv
// ---------------------------------------------------------------------------
// linebuffer_window41
//   Line-buffer stage in front of the 41-term inner-product block. Accepts a
//   raster-order pixel stream, keeps WIN_H-1 previous rows in line buffers and
//   presents one 41-entry feature vector per valid WIN_W x WIN_H window:
//     xarray[0]                 = BIAS (always, including during reset)
//     xarray[1 + r*WIN_W + c]   = pixel(row-(WIN_H-1)+r, col-(WIN_W-1)+c)
//   Parameters: IMG_W, IMG_H (image size), PIX_W (pixel width, zero-extended
//   to FEAT_W on output).
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous reset, active-high
//     bus   linebuffer_window41_if.slave (pixel in / window out handshakes)
//   Configuration macro LINEBUF_SOF_EN: when defined, bus.in_sof is sampled on
//   each accepted pixel and forces that pixel to (row 0, col 0).
// ---------------------------------------------------------------------------
module linebuffer_window41
  import linebuffer_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  linebuffer_window41_if.slave  bus
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int N_LB  = WIN_H - 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col_eff;
  logic [ROW_W-1:0] row_eff;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;

  logic             sof;
  logic             in_ready_w;
  logic             out_valid_q;
  logic             pix_acc;
  logic             win_acc;
  logic             qualify;

  logic [PIX_W-1:0] lb_wr   [0:N_LB-1];
  logic [PIX_W-1:0] lb_rd   [0:N_LB-1];
  logic [PIX_W-1:0] new_col [0:WIN_H-1];
  logic [PIX_W-1:0] win     [0:WIN_H-1][0:WIN_W-1];

`ifdef LINEBUF_SOF_EN
  assign sof = bus.in_sof;
`else
  assign sof = 1'b0;
`endif

  // Single-entry skid: a pixel may enter only if the current window slot is
  // empty or is being drained in the same cycle.
  assign in_ready_w    = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign pix_acc       = bus.in_valid && in_ready_w;
  assign win_acc       = out_valid_q && bus.out_ready;

  // A start-of-frame pixel is placed at (0,0) before anything else looks at
  // the position, so RAM address, qualification and wrap all see it.
  always_comb begin
    col_eff = sof ? '0 : col;
    row_eff = sof ? '0 : row;
  end

  always_comb begin
    col_nxt = col_eff + 1'b1;
    row_nxt = row_eff;
    if (col_eff == COL_W'(IMG_W - 1)) begin
      col_nxt = '0;
      if (row_eff == ROW_W'(IMG_H - 1)) begin
        row_nxt = '0;
      end else begin
        row_nxt = row_eff + 1'b1;
      end
    end
  end

  // Validity comes only from the position counters; rows above WIN_H-1 and
  // the first WIN_W-1 columns of every row only prime the window, which also
  // keeps stale RAM contents out of any presented window.
  assign qualify = (row_eff >= ROW_W'(WIN_H - 1)) && (col_eff >= COL_W'(WIN_W - 1));

  // Vertical cascade: buffer 0 holds row-1, buffer i holds row-1-i. Each
  // accept pushes the column one buffer further down.
  always_comb begin
    for (int i = 0; i < N_LB; i++) begin
      lb_wr[i] = (i == 0) ? bus.in_pix : lb_rd[(i == 0) ? 0 : i - 1];
    end
  end

  // Column entering the window: top entry is the oldest buffered row, bottom
  // entry is the incoming pixel.
  always_comb begin
    new_col[WIN_H-1] = bus.in_pix;
    for (int r = 0; r < WIN_H - 1; r++) begin
      new_col[r] = lb_rd[WIN_H-2-r];
    end
  end

  for (genvar i = 0; i < N_LB; i++) begin : g_lb
    linebuffer_row_ram #(
      .DEPTH  (IMG_W),
      .WIDTH  (PIX_W),
      .ADDR_W (COL_W)
    ) u_ram (
      .clk   (clk),
      .we    (pix_acc),
      .addr  (col_eff),
      .wdata (lb_wr[i]),
      .rdata (lb_rd[i])
    );
  end

  // Position counters, window shift register and the output-valid flag all
  // move only on an accepted pixel, which is what keeps xarray stable while a
  // window is stalled. A window drained with no new qualifying pixel clears
  // out_valid; a drain together with a qualifying pixel replaces it in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      out_valid_q <= 1'b0;
      for (int r = 0; r < WIN_H; r++) begin
        for (int c = 0; c < WIN_W; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      if (pix_acc) begin
        col         <= col_nxt;
        row         <= row_nxt;
        out_valid_q <= qualify;
        for (int r = 0; r < WIN_H; r++) begin
          for (int c = 0; c < WIN_W - 1; c++) begin
            win[r][c] <= win[r][c+1];
          end
          win[r][WIN_W-1] <= new_col[r];
        end
      end else if (win_acc) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.xarray[0] = BIAS;
    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W; c++) begin
        bus.xarray[feat_index(r, c)] = feat_t'(win[r][c]);
      end
    end
  end

endmodule

// File: tb/tb_linebuffer_window41.sv
// ---------------------------------------------------------------------------
// tb_linebuffer_window41
//   Self-checking bench for linebuffer_window41 at IMG_W=16, IMG_H=8, PIX_W=8.
//   The reference keeps the current frame as a 2-D image and, for every
//   qualifying accepted pixel, queues the expected 41-entry vector built
//   straight from the window mapping. Define LINEBUF_SOF_EN to add the
//   start-of-frame scenario.
// ---------------------------------------------------------------------------
module tb_linebuffer_window41;
  import linebuffer_pkg::*;

  localparam int IMG_W = 16;
  localparam int IMG_H = 8;
  localparam int PIX_W = 8;
  localparam int FRAME = IMG_W * IMG_H;

  typedef logic [N_FEAT*FEAT_W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  linebuffer_window41_if #(.PIX_W(PIX_W)) bus ();

  linebuffer_window41 #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [PIX_W-1:0] img [0:IMG_H-1][0:IMG_W-1];
  vec_t expq [$];
  int   nxt_r = 0;
  int   nxt_c = 0;
  int   windows = 0;
  int   pixmode = 0;
  int   stall_left = 0;
  bit   stall_armed = 1'b0;
  bit   spot_pending = 1'b0;
  bit   sof_next = 1'b0;
  bit   accepted = 1'b0;

  function automatic vec_t buildWindow(input int r, input int c);
    vec_t v;
    v = '0;
    v[0 +: FEAT_W] = 32'd1;
    for (int wr = 0; wr < WIN_H; wr++) begin
      for (int wc = 0; wc < WIN_W; wc++) begin
        v[(1 + wr*WIN_W + wc)*FEAT_W +: FEAT_W] =
          {24'd0, img[r-(WIN_H-1)+wr][c-(WIN_W-1)+wc]};
      end
    end
    return v;
  endfunction

  function automatic vec_t packObs();
    vec_t v;
    for (int i = 0; i < N_FEAT; i++) begin
      v[i*FEAT_W +: FEAT_W] = bus.xarray[i];
    end
    return v;
  endfunction

  function automatic int firstDiff(input vec_t a, input vec_t b);
    for (int i = 0; i < N_FEAT; i++) begin
      if (a[i*FEAT_W +: FEAT_W] !== b[i*FEAT_W +: FEAT_W]) return i;
    end
    return 0;
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge: compares DUT outputs with the reference, then
  // advances the reference by whatever transfers happen at the next edge.
  task automatic checkOutput();
    logic exp_valid;
    vec_t obs;
    int   idx;
    exp_valid = (expq.size() != 0);
    accepted  = 1'b0;
    if (spot_pending) begin
      checkWord("first x0",  bus.xarray[0],  32'd1);
      checkWord("first x1",  bus.xarray[1],  32'd0);
      checkWord("first x8",  bus.xarray[8],  32'd7);
      checkWord("first x33", bus.xarray[33], 32'd64);
      checkWord("first x40", bus.xarray[40], 32'd71);
      spot_pending = 1'b0;
    end
    checkBit("out_valid", bus.out_valid, exp_valid);
    checkBit("in_ready", bus.in_ready, !exp_valid || bus.out_ready);
    checkWord("bias", bus.xarray[0], 32'd1);
    if (exp_valid) begin
      obs = packObs();
      checks++;
      assert (obs === expq[0]) else begin
        errors++;
        idx = firstDiff(obs, expq[0]);
        $error("[TB] FAIL window %0d: xarray[%0d] observed %0d expected %0d",
               windows, idx, obs[idx*FEAT_W +: FEAT_W], expq[0][idx*FEAT_W +: FEAT_W]);
      end
      if (bus.out_ready) begin
        void'(expq.pop_front());
        windows++;
      end
    end
    if (bus.in_valid && (!exp_valid || bus.out_ready)) begin
      accepted = 1'b1;
      sof_next = 1'b0;
      img[nxt_r][nxt_c] = bus.in_pix;
      if (nxt_r >= WIN_H-1 && nxt_c >= WIN_W-1) begin
        expq.push_back(buildWindow(nxt_r, nxt_c));
        if (pixmode == 0 && nxt_r == WIN_H-1 && nxt_c == WIN_W-1) spot_pending = 1'b1;
      end
      if (nxt_c == IMG_W-1) begin
        nxt_c = 0;
        nxt_r = (nxt_r == IMG_H-1) ? 0 : nxt_r + 1;
      end else begin
        nxt_c++;
      end
    end
  endtask

  // One clock: drive inputs just after the posedge, check at the negedge.
  task automatic applyStimulus(input logic v, input logic ordy);
    bus.in_valid  = v;
    bus.out_ready = ordy;
    if (v && pixmode == 0) bus.in_pix = 8'((nxt_r * 16 + nxt_c) % 256);
    else                   bus.in_pix = 8'($urandom);
`ifdef LINEBUF_SOF_EN
    bus.in_sof = v ? sof_next : 1'($urandom_range(0, 1));
`endif
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 always ready, 1 random.
  task automatic streamPixels(input int npix, input int vmode, input int rmode);
    int   sent;
    int   budget;
    int   cyc;
    logic v;
    logic o;
    sent = 0;
    cyc = 0;
    budget = npix * 8 + 100;
    while (sent < npix && budget > 0) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      o = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (stall_armed && expq.size() != 0) begin
        stall_left  = 5;
        stall_armed = 1'b0;
      end
      if (stall_left > 0) begin
        o = 1'b0;
        v = 1'b1;
        stall_left--;
      end
      applyStimulus(v, o);
      if (accepted) sent++;
      cyc++;
      budget--;
    end
    checkCount("pixels accepted within budget", sent, npix);
  endtask

  task automatic drain();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic resetChecks();
    checkBit("reset out_valid", bus.out_valid, 1'b0);
    checkBit("reset in_ready", bus.in_ready, 1'b1);
    checkWord("reset bias", bus.xarray[0], 32'd1);
    for (int i = 1; i < N_FEAT; i++) begin
      checkWord($sformatf("reset xarray[%0d]", i), bus.xarray[i], 32'd0);
    end
  endtask

  // Asynchronous reset asserted between clock edges and checked before the
  // next edge arrives.
  task automatic doReset();
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    resetChecks();
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    nxt_r = 0;
    nxt_c = 0;
    spot_pending = 1'b0;
    windows = 0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.out_ready = 1'b0;
`ifdef LINEBUF_SOF_EN
    bus.in_sof    = 1'b0;
`endif
    #4;
    resetChecks();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] scenario 1: one frame, out_ready=1");
    pixmode = 0;
    windows = 0;
    streamPixels(FRAME, 0, 0);
    drain();
    checkCount("s1 windows", windows, 36);

    $display("[TB] scenario 2: 5-cycle stall at first window");
    windows = 0;
    stall_armed = 1'b1;
    streamPixels(FRAME, 0, 0);
    drain();
    checkCount("s2 windows", windows, 36);

    $display("[TB] scenario 3: two back-to-back frames");
    windows = 0;
    streamPixels(2 * FRAME, 0, 0);
    drain();
    checkCount("s3 windows", windows, 72);

    $display("[TB] scenario 4: reset with a stalled window, then mid-frame at (5,3)");
    streamPixels(4 * IMG_W + WIN_W, 0, 0);
    applyStimulus(1'b0, 1'b0);
    doReset();
    streamPixels(5 * IMG_W + 3, 0, 0);
    doReset();
    streamPixels(FRAME, 0, 0);
    drain();
    checkCount("s4 windows", windows, 36);

    $display("[TB] scenario 5: in_valid toggling");
    windows = 0;
    streamPixels(FRAME, 1, 0);
    drain();
    checkCount("s5 windows", windows, 36);

    $display("[TB] scenario 6: random pixels, random valid/ready, three frames");
    pixmode = 1;
    windows = 0;
    streamPixels(3 * FRAME, 2, 1);
    drain();
    checkCount("s6 windows", windows, 108);

`ifdef LINEBUF_SOF_EN
    $display("[TB] scenario 7: in_sof at pixel (6,2)");
    pixmode = 0;
    windows = 0;
    streamPixels(6 * IMG_W + 2, 0, 0);
    nxt_r = 0;
    nxt_c = 0;
    sof_next = 1'b1;
    windows = 0;
    streamPixels(FRAME, 0, 0);
    drain();
    checkCount("s7 windows", windows, 36);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
